// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle LSL/LSR/ASR/ROR shifter, one bit per cycle,
// producing [N,Z,C,V] flags when the S bit is set.
//
// Handshake: a request is taken on the rising edge where in_valid and
// in_ready are both 1; in_ready is 1 only while idle. A result is taken on
// the rising edge where out_valid and out_ready are both 1; result and
// flag_out are held stable while out_valid=1 and out_ready=0. in_valid seen
// while busy is ignored, and the unit returns to idle for at least one cycle
// between results (no overlap).
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             s,
  input  logic [3:0]       flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag_out,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Largest useful step counts: one past the width for logical shifts (so
  // the carry also clears), exactly the width for ASR (sign saturates).
  localparam int unsigned W_U     = WIDTH;
  localparam int unsigned LOG_MAX = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched request and working registers.
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [1:0]       op_q;
  logic             s_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] count;

  // Combinational helpers.
  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] n_iter;
  int unsigned      amt_u;
  logic [WIDTH-1:0] step_work;
  logic             step_carry;

  // Flag vector seen on the result: computed when s is set, else passthrough.
  function automatic logic [3:0] make_flags(
    input logic [WIDTH-1:0] value,
    input logic             c,
    input logic             upd,
    input logic [3:0]       prev
  );
    logic [3:0] f;
    if (upd) begin
      f = {value[WIDTH-1], (value == '0), c, prev[0]};
    end else begin
      f = prev;
    end
    return f;
  endfunction

  assign accept    = in_valid && (state == ST_IDLE);
  assign last_step = (count == CNT_W'(1));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign fsm_state = state;

  // Iteration count for an incoming request, clamped per shift kind.
  always_comb begin
    amt_u  = 32'(amount);
    n_iter = '0;
    case (op)
      OP_LSL, OP_LSR: begin
        n_iter = (amt_u > LOG_MAX) ? CNT_W'(LOG_MAX) : CNT_W'(amt_u);
      end
      OP_ASR: begin
        n_iter = (amt_u > W_U) ? CNT_W'(W_U) : CNT_W'(amt_u);
      end
      default: begin
        // ROR: a multiple of the width still runs a full turn so the carry
        // ends up holding the original MSB.
        if (amt_u == 32'd0) begin
          n_iter = '0;
        end else begin
          n_iter = CNT_W'(((amt_u - 32'd1) % W_U) + 32'd1);
        end
      end
    endcase
  end

  // Single-bit step of the working register and carry for the latched op.
  always_comb begin
    step_work  = work;
    step_carry = carry;
    case (op_q)
      OP_LSL: begin
        step_work  = {work[WIDTH-2:0], 1'b0};
        step_carry = work[WIDTH-1];
      end
      OP_LSR: begin
        step_work  = {1'b0, work[WIDTH-1:1]};
        step_carry = work[0];
      end
      OP_ASR: begin
        step_work  = {work[WIDTH-1], work[WIDTH-1:1]};
        step_carry = work[0];
      end
      default: begin
        step_work  = {work[0], work[WIDTH-1:1]};
        step_carry = work[0];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (n_iter == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch on accept, step while shifting, register the result
  // and flags on the transition into DONE so they hold through backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work     <= '0;
      carry    <= 1'b0;
      op_q     <= 2'b00;
      s_q      <= 1'b0;
      flags_q  <= 4'b0000;
      count    <= '0;
      result   <= '0;
      flag_out <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work    <= operand;
            carry   <= flag_in[1];
            op_q    <= op;
            s_q     <= s;
            flags_q <= flag_in;
            count   <= n_iter;
            if (n_iter == '0) begin
              result   <= operand;
              flag_out <= make_flags(operand, flag_in[1], s, flag_in);
            end
          end
        end
        ST_SHIFT: begin
          work  <= step_work;
          carry <= step_carry;
          count <= count - CNT_W'(1);
          if (last_step) begin
            result   <= step_work;
            flag_out <= make_flags(step_work, step_carry, s_q, flags_q);
          end
        end
        default: begin
          // DONE: hold everything until the consumer takes the result.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit at WIDTH=32: a table of shift vectors
// with hand-computed results, flags and latencies, plus sequences for
// backpressure and asynchronous reset in the middle of an operation.
module tb_seq_shift_unit;

  localparam int WIDTH = 32;
  localparam int AMT_W = 8;
  localparam int CNT_W = 8;

  // Clock / reset block.
  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             s;
  logic [3:0]       flag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flag_out;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .amount    (amount),
    .s         (s),
    .flag_in   (flag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_out  (flag_out),
    .fsm_state (fsm_state)
  );

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             s;
    logic [3:0]       flag_in;
    logic [WIDTH-1:0] exp_result;
    logic [3:0]       exp_flags;
    int               exp_lat;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard.
  logic [WIDTH-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] v_op, input logic [WIDTH-1:0] v_operand,
                         input logic [AMT_W-1:0] v_amount, input logic v_s,
                         input logic [3:0] v_flag_in, input logic [WIDTH-1:0] v_res,
                         input logic [3:0] v_flags, input int v_lat);
    vec_t v;
    v.op         = v_op;
    v.operand    = v_operand;
    v.amount     = v_amount;
    v.s          = v_s;
    v.flag_in    = v_flag_in;
    v.exp_result = v_res;
    v.exp_flags  = v_flags;
    v.exp_lat    = v_lat;
    vecs.push_back(v);
  endtask

  // Driver: issue one request, scramble inputs after accept, measure the
  // number of rising edges from the accept edge to out_valid, then retire.
  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    logic [WIDTH-1:0] exp_res;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = v.op;
    operand  = v.operand;
    amount   = v.amount;
    s        = v.s;
    flag_in  = v.flag_in;
    exp_q.push_back(v.exp_result);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    op       = ~v.op;
    operand  = ~v.operand;
    amount   = v.amount + 8'd3;
    s        = ~v.s;
    flag_in  = ~v.flag_in;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    exp_res = exp_q.pop_front();
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(v.exp_lat));
    check({name, " result"}, result, exp_res);
    check({name, " flag_out"}, 32'(flag_out), 32'(v.exp_flags));
    check({name, " busy in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({name, " retire out_valid"}, 32'(out_valid), 32'd0);
    check({name, " retire in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Watchdog in case the stimulus itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t base;
    bit seen;

    // Table: op, operand, amount, s, flag_in, result, flags, latency.
    add_vec(2'b00, 32'h0000_0003,  8'd1, 1'b1, 4'b0000, 32'h0000_0006, 4'b0000,  2);
    add_vec(2'b00, 32'h8000_0000,  8'd1, 1'b1, 4'b0000, 32'h0000_0000, 4'b0110,  2);
    add_vec(2'b10, 32'hFFFF_FFFA,  8'd4, 1'b0, 4'b1010, 32'hFFFF_FFFF, 4'b1010,  5);
    add_vec(2'b11, 32'h8000_0001,  8'd1, 1'b1, 4'b0001, 32'hC000_0000, 4'b1011,  2);
    add_vec(2'b01, 32'hFFFF_FFFF,  8'd40, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 34);
    add_vec(2'b00, 32'h0000_000A,  8'd32, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 33);
    add_vec(2'b11, 32'h8000_0000,  8'd64, 1'b1, 4'b0000, 32'h8000_0000, 4'b1010, 33);
    add_vec(2'b01, 32'h1234_5678,  8'd0, 1'b1, 4'b0011, 32'h1234_5678, 4'b0011,  1);
    add_vec(2'b00, 32'hFFFF_FFFF,  8'd33, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 34);
    add_vec(2'b01, 32'h8000_0000,  8'd32, 1'b1, 4'b0000, 32'h0000_0000, 4'b0110, 33);
    add_vec(2'b10, 32'h8000_0000,  8'd40, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b1010, 33);
    add_vec(2'b10, 32'h7FFF_FFFF,  8'd200, 1'b1, 4'b0001, 32'h0000_0000, 4'b0101, 33);
    add_vec(2'b11, 32'h0000_001F,  8'd4, 1'b1, 4'b0000, 32'hF000_0001, 4'b1010,  5);
    add_vec(2'b11, 32'h0000_0003,  8'd33, 1'b1, 4'b0000, 32'h8000_0001, 4'b1010,  2);
    add_vec(2'b00, 32'h0000_0001,  8'd31, 1'b1, 4'b0000, 32'h8000_0000, 4'b1000, 32);
    add_vec(2'b00, 32'h0000_0003,  8'd1, 1'b0, 4'b0101, 32'h0000_0006, 4'b0101,  2);

    // Reset.
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    operand   = '0;
    amount    = '0;
    s         = 1'b0;
    flag_in   = 4'b0000;
    out_ready = 1'b1;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'h0);
    check("reset flag_out", 32'(flag_out), 32'h0);
    check("reset state", 32'(fsm_state), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: DONE held for 5 clocks, in_valid meanwhile ignored.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 2'b00;
    operand   = 32'h0000_0003;
    amount    = 8'd1;
    s         = 1'b1;
    flag_in   = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op       = 2'b11;
      operand  = 32'hDEAD_BEEF;
      amount   = 8'd5;
      flag_in  = 4'b1111;
      check($sformatf("bp hold result %0d", i), result, 32'h0000_0006);
      check($sformatf("bp hold flag_out %0d", i), 32'(flag_out), 32'h0);
      check($sformatf("bp hold in_ready %0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp hold out_valid %0d", i), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release result", result, 32'h0000_0006);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    in_valid = 1'b1;
    op       = 2'b01;
    operand  = 32'hFFFF_FFFF;
    amount   = 8'd40;
    s        = 1'b1;
    flag_in  = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid shift state", 32'(fsm_state), 32'd1);
    reset = 1'b1;
    #1;
    check("shift rst out_valid", 32'(out_valid), 32'd0);
    check("shift rst in_ready", 32'(in_ready), 32'd1);
    check("shift rst result", result, 32'h0);
    check("shift rst flag_out", 32'(flag_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("shift rst no result", 32'(seen), 32'd0);

    // Reset in the middle of DONE.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 2'b00;
    operand   = 32'h0000_0005;
    amount    = 8'd2;
    s         = 1'b1;
    flag_in   = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("done rst");
    check("done rst pre result", result, 32'h0000_0014);
    reset = 1'b1;
    #1;
    check("done rst out_valid", 32'(out_valid), 32'd0);
    check("done rst in_ready", 32'(in_ready), 32'd1);
    check("done rst result", result, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;

    // Normal operation after the aborts.
    base.op         = 2'b11;
    base.operand    = 32'h8000_0001;
    base.amount     = 8'd1;
    base.s          = 1'b1;
    base.flag_in    = 4'b0001;
    base.exp_result = 32'hC000_0000;
    base.exp_flags  = 4'b1011;
    base.exp_lat    = 2;
    run_vec(base, "after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
